// File: rtl/rnd_pkg.sv
// Shared definitions for the random-bit harvester: FSM encoding,
// parameter defaults and the accumulator shift helper.
package rnd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DEBIAS  = 3'd4,
        ST_OUTPUT  = 3'd5
    } state_t;

    localparam int N_DEF             = 8;
    localparam int ARM_CYCLES_DEF    = 2;
    localparam int SETTLE_CYCLES_DEF = 3;
    localparam int STUCK_LIMIT_DEF   = 16;

    // Shift one debiased bit into the byte accumulator (newest bit at LSB).
    function automatic logic [7:0] shift_in(input logic [7:0] acc, input logic b);
        return {acc[6:0], b};
    endfunction

endpackage

// File: rtl/rnd_sync.sv
// Two-stage synchronizer bringing the asynchronous raw latch bits into clk.
module rnd_sync #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] meta;

    // Free-running double flop; only reset interrupts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rnd_harvester.sv
// Excites an external metastable latch bank, captures its settled bits and
// runs a von Neumann debiaser over them, packing the result into bytes.
module rnd_harvester
    import rnd_pkg::*;
#(
    parameter int N             = N_DEF,
    parameter int ARM_CYCLES    = ARM_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int STUCK_LIMIT   = STUCK_LIMIT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic         gen_g,
    input  logic [N-1:0] raw_in,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         stuck_err
);

    // k must be able to hold N/2 so a byte finishing on the last pair is
    // distinguishable from one that still has pairs left.
    localparam int KW    = $clog2(N/2 + 1);
    localparam int CMAX  = (ARM_CYCLES > SETTLE_CYCLES) ? ARM_CYCLES : SETTLE_CYCLES;
    localparam int CW    = (CMAX < 2) ? 1 : $clog2(CMAX);
    localparam int SW    = $clog2(STUCK_LIMIT + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sync_bits;
    logic [N-1:0]  sample;
    logic [N-1:0]  prev_sample;
    logic          first_cap;
    logic [KW-1:0] k;
    logic [7:0]    acc;
    logic [3:0]    bitcnt;
    logic [SW-1:0] stuck_cnt;

    logic          pa;
    logic          pb;
    logic          emit;
    logic [7:0]    acc_next;
    logic [SW-1:0] stuck_next;

    rnd_sync #(.N(N)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (sync_bits)
    );

    // Select the current pair (a = even bit, b = odd bit) and form the debiased bit.
    always_comb begin
        pa = 1'b0;
        pb = 1'b0;
        for (int i = 0; i < N/2; i++) begin
            if (k == KW'(i)) begin
                pa = sample[2*i];
                pb = sample[2*i+1];
            end
        end
        emit     = pa ^ pb;
        acc_next = shift_in(acc, pa);
    end

    // Saturating run length of identical captures.
    always_comb begin
        stuck_next = '0;
        if (sync_bits == prev_sample) begin
            stuck_next = (stuck_cnt == SW'(STUCK_LIMIT)) ? stuck_cnt : stuck_cnt + SW'(1);
        end
    end

    // Captured data registers; no reset needed since the FSM loads them before use.
    always_ff @(posedge clk) begin
        if (state == ST_CAPTURE) begin
            sample      <= sync_bits;
            prev_sample <= sync_bits;
        end
    end

    // Main control FSM with registered gen_g / out_valid / out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gen_g     <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            stuck_err <= 1'b0;
            acc       <= '0;
            bitcnt    <= '0;
            k         <= '0;
            stuck_cnt <= '0;
            cnt       <= '0;
            first_cap <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    gen_g <= 1'b1;
                    if (en) begin
                        state <= ST_ARM;
                        gen_g <= 1'b0;
                        cnt   <= '0;
                    end
                end

                ST_ARM: begin
                    if (cnt == CW'(ARM_CYCLES - 1)) begin
                        state <= ST_SETTLE;
                        gen_g <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_SETTLE: begin
                    if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                        state <= ST_CAPTURE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_CAPTURE: begin
                    k <= '0;
                    if (first_cap) begin
                        first_cap <= 1'b0;
                    end else begin
                        stuck_cnt <= stuck_next;
                        if (stuck_next == SW'(STUCK_LIMIT)) begin
                            stuck_err <= 1'b1;
                        end
                    end
                    state <= ST_DEBIAS;
                end

                ST_DEBIAS: begin
                    if (emit) begin
                        acc    <= acc_next;
                        bitcnt <= bitcnt + 4'd1;
                    end
                    if (emit && bitcnt == 4'd7) begin
                        state     <= ST_OUTPUT;
                        out_valid <= 1'b1;
                        out_data  <= acc_next;
                        k         <= k + KW'(1);
                    end else if (k == KW'(N/2 - 1)) begin
                        if (en) begin
                            state <= ST_ARM;
                            gen_g <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        k <= k + KW'(1);
                    end
                end

                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        bitcnt    <= '0;
                        if (k < KW'(N/2)) begin
                            state <= ST_DEBIAS;
                        end else if (en) begin
                            state <= ST_ARM;
                            gen_g <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    gen_g <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rnd_harvester.sv
// Scoreboard bench for rnd_harvester: each excitation's raw value feeds a
// reference debiaser whose bytes are queued and compared at each handshake.
module tb_rnd_harvester;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       gen_g;
    logic [7:0] raw_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       stuck_err;

    rnd_harvester dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .gen_g     (gen_g),
        .raw_in    (raw_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .stuck_err (stuck_err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_acc;
    int         m_cnt;
    int         mode;
    logic [7:0] const_val;
    int         idx;
    int         falls;
    int         pops;
    logic [7:0] last_pop;
    logic       saw_valid;
    logic       gprev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat();
        case (mode)
            1:       return idx[0] ? 8'h02 : 8'h01;
            2:       return (idx == 0) ? 8'h01 : 8'h99;
            default: return const_val;
        endcase
    endfunction

    // Reference von Neumann debiaser over the value applied for one excitation.
    task automatic model_sample(input logic [7:0] v);
        for (int p = 0; p < 4; p++) begin
            if (v[2*p] != v[2*p+1]) begin
                m_acc = {m_acc[6:0], v[2*p]};
                m_cnt++;
                if (m_cnt == 8) begin
                    exp_q.push_back(m_acc);
                    m_cnt = 0;
                end
            end
        end
    endtask

    // One clock: note a handshake pending at the edge, then after the edge
    // score it and feed a fresh raw value whenever a new excitation starts.
    task automatic step();
        logic       hs;
        logic [7:0] d;
        logic [7:0] v;
        hs = out_valid && out_ready && !rst;
        d  = out_data;
        @(posedge clk);
        #1;
        if (hs) begin
            chk("sb_nonempty", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("sb_byte", d, exp_q.pop_front());
            pops++;
            last_pop = d;
        end
        if (out_valid) saw_valid = 1'b1;
        if (!gen_g && gprev) begin
            v      = pat();
            raw_in = v;
            idx++;
            falls++;
            model_sample(v);
        end
        gprev = gen_g;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst       = 1'b0;
        exp_q.delete();
        m_acc     = '0;
        m_cnt     = 0;
        idx       = 0;
        falls     = 0;
        pops      = 0;
        saw_valid = 1'b0;
        gprev     = 1'b1;
    endtask

    initial begin
        int         n;
        int         lows;
        int         second;
        logic       gp;
        logic       ok;
        logic [7:0] d0;
        int         f0;

        rst = 1'b1; en = 1'b0; out_ready = 1'b1; raw_in = '0;
        mode = 0; const_val = 8'h00; gprev = 1'b1;
        m_acc = '0; m_cnt = 0; idx = 0; falls = 0; pops = 0;
        last_pop = '0; saw_valid = 1'b0;

        do_reset();
        chk("rst_gen_g", gen_g, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_stuck_err", stuck_err, 0);

        // Constant 0x99: timing of the excitation cycle and the first byte.
        mode = 0; const_val = 8'h99; en = 1'b1;
        n = 0;
        while (gen_g && n < 10) begin step(); n++; end
        chk("t035_arm_start", n, 1);
        n = 0; lows = 1; second = 0; gp = 1'b0;
        while (!out_valid && n < 60) begin
            step(); n++;
            if (n < 5 && !gen_g) lows++;
            if (!gen_g && gp && second == 0) second = n;
            gp = gen_g;
        end
        chk("t035_arm_len", lows, 2);
        chk("t035_rearm_at", second, 10);
        chk("t035_valid_at", n, 20);
        chk("t035_data", out_data, 8'hAA);
        en = 1'b0;
        repeat (25) step();
        chk("t035_pops", pops, 1);

        // Backpressure in OUTPUT, then resume on the remaining pair.
        do_reset();
        mode = 2; en = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin step(); n++; end
        chk("t037_wait", out_valid, 1);
        chk("t037_q", exp_q.size(), 1);
        if (exp_q.size() > 0) chk("t037_data", out_data, exp_q[0]);
        d0 = out_data; f0 = falls; ok = 1'b1;
        repeat (20) begin
            step();
            if (!(out_valid && out_data == d0 && gen_g)) ok = 1'b0;
        end
        chk("t037_hold", ok, 1);
        chk("t037_nofall", falls, f0);
        out_ready = 1'b1;
        n = 0;
        while (pops < 2 && n < 200) begin step(); n++; end
        chk("t037_pops", pops, 2);
        chk("t037_second", last_pop, 8'h55);

        // en falls while debiasing the second sample.
        do_reset();
        mode = 0; const_val = 8'h99; en = 1'b1;
        n = 0;
        while (falls < 2 && n < 100) begin step(); n++; end
        chk("t038_falls", falls, 2);
        repeat (7) step();
        en = 1'b0;
        n = 0;
        while (pops < 1 && n < 50) begin step(); n++; end
        chk("t038_pops", pops, 1);
        chk("t038_byte", last_pop, 8'hAA);
        f0 = falls; ok = 1'b1;
        repeat (30) begin
            step();
            if (!gen_g || out_valid) ok = 1'b0;
        end
        chk("t038_idle", ok, 1);
        chk("t038_nofall", falls, f0);

        // Alternating 0x01 / 0x02 per capture.
        do_reset();
        mode = 1; en = 1'b1;
        n = 0;
        while (pops < 1 && n < 300) begin step(); n++; end
        chk("t040_pops", pops, 1);
        chk("t040_byte", last_pop, 8'hAA);
        chk("t040_stuck", stuck_err, 0);

        // Stuck source at 0xFF, then reset while in ARM.
        do_reset();
        mode = 0; const_val = 8'hFF; en = 1'b1;
        n = 0;
        while (falls < 17 && n < 400) begin step(); n++; end
        chk("t036_falls", falls, 17);
        chk("t036_before", stuck_err, 0);
        repeat (7) step();
        chk("t036_after", stuck_err, 1);
        chk("t036_no_valid", saw_valid, 0);
        const_val = 8'h99;
        repeat (40) step();
        chk("t036_sticky", stuck_err, 1);
        n = 0;
        while (gen_g && n < 30) begin step(); n++; end
        chk("t039_in_arm", gen_g, 0);
        rst = 1'b1;
        step();
        chk("t039a_gen_g", gen_g, 1);
        chk("t039a_valid", out_valid, 0);
        chk("t039a_stuck", stuck_err, 0);
        rst = 1'b0;
        step();
        chk("t039a_rearm", gen_g, 0);
        en = 1'b0;

        // Reset while a byte waits in OUTPUT.
        do_reset();
        mode = 0; const_val = 8'h99; en = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 60) begin step(); n++; end
        chk("t039b_wait", out_valid, 1);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("t039b_valid", out_valid, 0);
        chk("t039b_gen_g", gen_g, 1);
        chk("t039b_data", out_data, 0);
        chk("t039b_stuck", stuck_err, 0);
        en = 1'b0; out_ready = 1'b1;
        do_reset();
        repeat (5) step();
        chk("t039b_idle", gen_g, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
